lock_code_sender: RTL and testbench
===================================

# lock_code_sender

Serial code transmitter that drives the combination-lock front end. On a start request it clears the lock's shift register, then shifts a parallel code into the lock one bit per strobe, most-significant bit first. It then samples the lock's unlock indication and reports pass/fail with a one-cycle done pulse. It sits between the keypad/control logic and the lock's serial `data_in`/`clk`/`clr_n` inputs.

## Interface
- `CODE_W`, default 3: code width in bits (≥1); equals the lock shift-register depth.
- `BIT_GAP`, default 4: idle cycles after each strobe (≥0); data_out holds during them.

- `clk`  in  1  system clock; all logic on rising edge.
- `clr_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  transaction request; sampled only in IDLE.
- `code`  in  CODE_W  code to send; captured on the accepted start cycle.
- `unlock_in`  in  1  lock's unlock indication (1 = unlocked).
- `data_out`  out  1  serial bit to the lock's data input.
- `shift_clk`  out  1  one-cycle strobe; its rising edge is the lock's shift clock.
- `lock_clr_n`  out  1  active-low clear to the lock; synchronous to shift_clk at the lock.
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  1  1 = lock reported unlocked; holds until next accepted start.

## Operation
- All outputs are registered. Reset values: data_out=0, shift_clk=0, lock_clr_n=1, busy=0, done=0, result=0, state=IDLE, counters=0.
- States: IDLE, CLR_SETUP, CLR_STROBE, BIT_SETUP, BIT_STROBE, BIT_GAP, CHECK.
- IDLE: if start=1, capture code into the shadow register, clear result, go to CLR_SETUP. Otherwise stay.
- CLR_SETUP: lock_clr_n=0, shift_clk=0, data_out=0. Go to CLR_STROBE.
- CLR_STROBE: lock_clr_n=0, shift_clk=1. This edge clears the lock. Set bit index to CODE_W-1 and go to BIT_SETUP.
- BIT_SETUP: lock_clr_n=1, shift_clk=0, data_out=shadow[bit index]. Go to BIT_STROBE.
- BIT_STROBE: shift_clk=1 with data_out unchanged. If BIT_GAP=0, go directly to the end-of-bit decision. Otherwise load the gap counter and go to BIT_GAP.
- BIT_GAP: shift_clk=0 and data_out held; stay for BIT_GAP cycles.
- End of bit: if bit index=0, go to CHECK. Otherwise decrement the index and go to BIT_SETUP.
- CHECK: result <= unlock_in, done=1, then go to IDLE.
- Bit order: shadow[CODE_W-1] is sent first. After all strobes, lock stage 0 holds shadow[0] and the deepest stage holds shadow[CODE_W-1].
- busy=1 in every state except IDLE. start is ignored while busy, including in the CHECK cycle.
- The shadow register isolates the transaction; changes on `code` after acceptance have no effect.
- Gap counter width is clog2(BIT_GAP+1), with a minimum of 1. Bit index width is clog2(CODE_W), with a minimum of 1.

## Timing
- Cycle 0 is the IDLE cycle in which start=1 is sampled. Outputs listed for cycle n are the values visible during cycle n.
- lock_clr_n=0 in cycles 1–2. shift_clk=1 in cycle 2 (clear strobe).
- Bit k (k=0..CODE_W-1, sent MSB first) starts at S_k = 3 + k·(2+BIT_GAP):
  - data_out is valid from S_k.
  - shift_clk=1 at S_k+1.
  - data_out stays stable through S_k+1+BIT_GAP.
- Data is set up one cycle before the strobe and held at least through the strobe cycle.
- CHECK, with done=1 and result updated, occurs at cycle 3 + CODE_W·(2+BIT_GAP). Defaults give cycle 21.
- busy=1 from cycle 1 through the CHECK cycle inclusive.
- Total shift_clk pulses per transaction: CODE_W+1.
- The earliest next accepted start is the cycle after CHECK. If start is held high, transactions repeat with exactly one IDLE cycle between them.
- unlock_in is sampled at least BIT_GAP+1 cycles after the last strobe, so the lock's combinational decode has settled.
- Reset mid-transaction: all outputs return to reset values on the next edge. The lock is not cleared by reset; the next transaction clears it.

## Test plan
- Defaults with a behavioural lock model (unlocks on 101), code=3'b101, start pulse at cycle 0:
  - shift_clk=1 at cycles 2, 4, 10, 16.
  - data_out=1/0/1 at cycles 3–8, 9–14 and 15–20 respectively.
  - done=1 and result=1 at cycle 21; busy low at cycle 22.
- code=3'b011 → result=0 at cycle 21. The next transaction with code=3'b101 → result=1, proving the lock is cleared before each code.
- Start re-asserted at cycles 5 and 21, and `code` changed at cycle 7 → no new transaction and the sent bits are unchanged; done pulses exactly once.
- clr_n=0 at cycle 12 for one cycle → at the next edge: busy=0, shift_clk=0, lock_clr_n=1, data_out=0, done=0, result=0. A subsequent start with code=3'b101 → result=1 at its relative cycle 21.
- BIT_GAP=0, CODE_W=3, code=3'b101:
  - strobes at cycles 2, 4, 6, 8; CHECK at cycle 9 with result=1.
  - with start held high, a second transaction is accepted at cycle 10.
- CODE_W=1, BIT_GAP=2, code=1'b1 → single data strobe at cycle 4; CHECK at cycle 7.

Source files
------------

// File: rtl/lock_code_sender.sv
// Serial code transmitter for the combination-lock front end: clears the lock,
// shifts a captured code MSB first with one strobe per bit, then reports unlock status.
module lock_code_sender #(
  parameter int CODE_W  = 3,
  parameter int BIT_GAP = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  input  logic              unlock_in,
  output logic              data_out,
  output logic              shift_clk,
  output logic              lock_clr_n,
  output logic              busy,
  output logic              done,
  output logic              result
);

  localparam int GAP_W = (BIT_GAP < 1) ? 1 : $clog2(BIT_GAP + 1);
  localparam int IDX_W = (CODE_W < 2) ? 1 : $clog2(CODE_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_SETUP,
    ST_CLR_STROBE,
    ST_BIT_SETUP,
    ST_BIT_STROBE,
    ST_BIT_GAP,
    ST_CHECK
  } state_t;

  state_t            state, state_nxt;
  logic [CODE_W-1:0] shadow, shadow_nxt;
  logic [IDX_W-1:0]  bit_idx, idx_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              bit_end;
  logic              data_nxt, sclk_nxt, lclr_nxt, busy_nxt, done_nxt, result_nxt;

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    idx_nxt    = bit_idx;
    gap_nxt    = gap_cnt;
    result_nxt = result;
    bit_end    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shadow_nxt = code;
          result_nxt = 1'b0;
          state_nxt  = ST_CLR_SETUP;
        end
      end
      ST_CLR_SETUP:  state_nxt = ST_CLR_STROBE;
      ST_CLR_STROBE: begin
        idx_nxt   = IDX_W'(CODE_W - 1);
        state_nxt = ST_BIT_SETUP;
      end
      ST_BIT_SETUP:  state_nxt = ST_BIT_STROBE;
      ST_BIT_STROBE: begin
        if (BIT_GAP == 0) begin
          bit_end = 1'b1;
        end else begin
          gap_nxt   = GAP_W'(BIT_GAP);
          state_nxt = ST_BIT_GAP;
        end
      end
      ST_BIT_GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          gap_nxt = '0;
          bit_end = 1'b1;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    // Result is captured on entry to CHECK so it is visible together with done.
    if (bit_end) begin
      if (bit_idx == '0) begin
        result_nxt = unlock_in;
        state_nxt  = ST_CHECK;
      end else begin
        idx_nxt   = bit_idx - IDX_W'(1);
        state_nxt = ST_BIT_SETUP;
      end
    end

    // Outputs are decoded from the next state so every output is a plain register.
    data_nxt = data_out;
    sclk_nxt = 1'b0;
    lclr_nxt = 1'b1;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_CHECK);
    case (state_nxt)
      ST_CLR_SETUP: begin
        lclr_nxt = 1'b0;
        data_nxt = 1'b0;
      end
      ST_CLR_STROBE: begin
        lclr_nxt = 1'b0;
        sclk_nxt = 1'b1;
      end
      ST_BIT_SETUP:  data_nxt = shadow_nxt[idx_nxt];
      ST_BIT_STROBE: sclk_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      data_out   <= 1'b0;
      shift_clk  <= 1'b0;
      lock_clr_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_idx    <= idx_nxt;
      gap_cnt    <= gap_nxt;
      data_out   <= data_nxt;
      shift_clk  <= sclk_nxt;
      lock_clr_n <= lclr_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      result     <= result_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shadow <= shadow_nxt;
  end

endmodule

// File: tb/tb_lock_code_sender.sv
// Scoreboard bench for lock_code_sender: three instances (default, BIT_GAP=0, CODE_W=1)
// each driving a behavioural lock; expected strobes and results are queued at start time.
module tb_lock_code_sender;

  logic       clk = 1'b0;
  logic [2:0] clr_n = 3'b000;
  logic [2:0] start = 3'b000;
  logic [2:0] code0 = 3'b000;
  logic [2:0] code1 = 3'b000;
  logic [0:0] code2 = 1'b0;
  logic [2:0] unlock;
  logic [2:0] dout, sclk, lclr, busy, done, res;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int   cyc;
    logic data;
    logic clr_n;
  } strobe_t;

  typedef struct {
    int   cyc;
    logic res;
  } done_t;

  strobe_t sq[3][$];
  done_t   dq[3][$];
  int      gaps[3] = '{4, 0, 2};
  int      hold_from[3] = '{0, 0, 0};
  int      hold_until[3] = '{-1, -1, -1};
  logic    hold_val[3];
  logic    prev_dout[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lock_code_sender #(.CODE_W(3), .BIT_GAP(4)) u_dut0 (
    .clk(clk), .clr_n(clr_n[0]), .start(start[0]), .code(code0), .unlock_in(unlock[0]),
    .data_out(dout[0]), .shift_clk(sclk[0]), .lock_clr_n(lclr[0]),
    .busy(busy[0]), .done(done[0]), .result(res[0])
  );

  lock_code_sender #(.CODE_W(3), .BIT_GAP(0)) u_dut1 (
    .clk(clk), .clr_n(clr_n[1]), .start(start[1]), .code(code1), .unlock_in(unlock[1]),
    .data_out(dout[1]), .shift_clk(sclk[1]), .lock_clr_n(lclr[1]),
    .busy(busy[1]), .done(done[1]), .result(res[1])
  );

  lock_code_sender #(.CODE_W(1), .BIT_GAP(2)) u_dut2 (
    .clk(clk), .clr_n(clr_n[2]), .start(start[2]), .code(code2), .unlock_in(unlock[2]),
    .data_out(dout[2]), .shift_clk(sclk[2]), .lock_clr_n(lclr[2]),
    .busy(busy[2]), .done(done[2]), .result(res[2])
  );

  // Behavioural locks: first bit shifted in ends up in the deepest stage.
  logic [2:0] lk0 = 3'b000;
  logic [2:0] lk1 = 3'b000;
  logic       lk2 = 1'b0;
  always @(posedge sclk[0]) lk0 <= lclr[0] ? {lk0[1:0], dout[0]} : 3'b000;
  always @(posedge sclk[1]) lk1 <= lclr[1] ? {lk1[1:0], dout[1]} : 3'b000;
  always @(posedge sclk[2]) lk2 <= lclr[2] ? dout[2] : 1'b0;
  assign unlock[0] = (lk0 == 3'b101);
  assign unlock[1] = (lk1 == 3'b101);
  assign unlock[2] = lk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    else
      n_pass++;
  endtask

  task automatic push_txn(input int d, input int t0, input logic [2:0] c, input int cw,
                          input int gap, input logic exp_res);
    strobe_t e;
    done_t   de;
    e.cyc = t0 + 2; e.data = 1'b0; e.clr_n = 1'b0;
    sq[d].push_back(e);
    for (int k = 0; k < cw; k++) begin
      e.cyc   = t0 + 3 + k * (2 + gap) + 1;
      e.data  = c[cw-1-k];
      e.clr_n = 1'b1;
      sq[d].push_back(e);
    end
    de.cyc = t0 + 3 + cw * (2 + gap);
    de.res = exp_res;
    dq[d].push_back(de);
  endtask

  // Advance to 1 time unit after the edge that begins cycle c.
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!clr_n[d]) begin
        sq[d].delete();
        dq[d].delete();
        hold_until[d] = -1;
      end else begin
        if (cyc > hold_from[d] && cyc <= hold_until[d])
          chk("data_hold", dout[d], hold_val[d]);
        if (sclk[d] === 1'b1) begin
          chk("strobe_expected", sq[d].size() != 0, 1);
          if (sq[d].size() != 0) begin
            strobe_t e;
            e = sq[d].pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_clr_n", lclr[d], e.clr_n);
            if (e.clr_n) begin
              chk("data_setup", prev_dout[d], e.data);
              chk("data_strobe", dout[d], e.data);
              hold_from[d]  = cyc;
              hold_until[d] = cyc + gaps[d];
              hold_val[d]   = e.data;
            end
          end
        end
        if (done[d] === 1'b1) begin
          chk("done_expected", dq[d].size() != 0, 1);
          chk("busy_at_done", busy[d], 1);
          if (dq[d].size() != 0) begin
            done_t de;
            de = dq[d].pop_front();
            chk("done_cycle", cyc, de.cyc);
            chk("result", res[d], de.res);
          end
        end
      end
      prev_dout[d] = dout[d];
    end
  end

  initial begin
    int t;
    at(2);
    @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_shift_clk", sclk[0], 0);
    chk("rst_lock_clr_n", lclr[0], 1);
    chk("rst_data_out", dout[0], 0);
    chk("rst_result", res[0], 0);
    at(3);
    clr_n = 3'b111;

    // Defaults, code 101
    at(5);
    t = cyc; code0 = 3'b101; start[0] = 1'b1; push_txn(0, t, 3'b101, 3, 4, 1'b1);
    at(t + 1); start[0] = 1'b0;
    @(negedge clk);
    chk("busy_c1", busy[0], 1);
    chk("lock_clr_c1", lclr[0], 0);
    at(t + 22);
    @(negedge clk);
    chk("busy_c22", busy[0], 0);

    // Wrong code, then right code: lock must be cleared between them
    at(t + 25);
    t = cyc; code0 = 3'b011; start[0] = 1'b1; push_txn(0, t, 3'b011, 3, 4, 1'b0);
    at(t + 1); start[0] = 1'b0;
    at(t + 23);
    t = cyc; code0 = 3'b101; start[0] = 1'b1; push_txn(0, t, 3'b101, 3, 4, 1'b1);
    at(t + 1); start[0] = 1'b0;

    // start re-asserted mid-transaction and in CHECK; code changed after acceptance
    at(t + 23);
    t = cyc; code0 = 3'b101; start[0] = 1'b1; push_txn(0, t, 3'b101, 3, 4, 1'b1);
    at(t + 1);  start[0] = 1'b0;
    at(t + 5);  start[0] = 1'b1;
    at(t + 6);  start[0] = 1'b0;
    at(t + 7);  code0 = 3'b010;
    at(t + 21); start[0] = 1'b1;
    at(t + 22); start[0] = 1'b0;
    @(negedge clk);
    chk("no_restart_c22", busy[0], 0);
    at(t + 24);
    @(negedge clk);
    chk("no_restart_c24", busy[0], 0);

    // Reset mid-transaction, then a clean transaction
    at(t + 26);
    t = cyc; code0 = 3'b110; start[0] = 1'b1; push_txn(0, t, 3'b110, 3, 4, 1'b0);
    at(t + 1);  start[0] = 1'b0;
    at(t + 12); clr_n[0] = 1'b0;
    at(t + 13); clr_n[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_shift_clk", sclk[0], 0);
    chk("mid_rst_lock_clr_n", lclr[0], 1);
    chk("mid_rst_data_out", dout[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_result", res[0], 0);
    at(t + 15);
    t = cyc; code0 = 3'b101; start[0] = 1'b1; push_txn(0, t, 3'b101, 3, 4, 1'b1);
    at(t + 1); start[0] = 1'b0;
    at(t + 24);

    // BIT_GAP=0 with start held high: back-to-back transactions
    t = cyc; code1 = 3'b101; start[1] = 1'b1; push_txn(1, t, 3'b101, 3, 0, 1'b1);
    at(t + 5);  code1 = 3'b011;
    at(t + 10); push_txn(1, t + 10, 3'b011, 3, 0, 1'b0);
    @(negedge clk);
    chk("gap0_idle_c10", busy[1], 0);
    at(t + 11); start[1] = 1'b0;
    @(negedge clk);
    chk("gap0_busy_c11", busy[1], 1);
    at(t + 22);

    // CODE_W=1, BIT_GAP=2
    t = cyc; code2 = 1'b1; start[2] = 1'b1; push_txn(2, t, 3'b001, 1, 2, 1'b1);
    at(t + 1); start[2] = 1'b0;
    at(t + 9);
    t = cyc; code2 = 1'b0; start[2] = 1'b1; push_txn(2, t, 3'b000, 1, 2, 1'b0);
    at(t + 1); start[2] = 1'b0;
    at(t + 12);

    for (int d = 0; d < 3; d++) begin
      chk("strobes_all_seen", sq[d].size(), 0);
      chk("dones_all_seen", dq[d].size(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
